// File: rtl/timer_pkg.sv
// timer_pkg: shared constants and types for the timer peripheral.
// Holds register addresses, CTRL bit positions, mode codes, FSM states.
package timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int EN      = 0;
  localparam int MODE_LO = 1;
  localparam int MODE_HI = 2;
  localparam int IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CNT,
    INT
  } state_t;

endpackage

// File: rtl/timer.sv
// timer: memory-mapped 32-bit down counter with maskable IRQ.
// Ports: Clock, Reset (sync, high), Addr[3:2], WE, WD -> RD, IRQ.
module timer
  import timer_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [3:2]  Addr,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        IRQ
);

  state_t      state, state_n;
  logic [3:0]  ctrl, ctrl_n;
  logic [31:0] preset, preset_n;
  logic [31:0] count, count_n;
  logic        pend, pend_n;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= IDLE;
      ctrl   <= '0;
      preset <= '0;
      count  <= '0;
      pend   <= 1'b0;
    end else begin
      state  <= state_n;
      ctrl   <= ctrl_n;
      preset <= preset_n;
      count  <= count_n;
      pend   <= pend_n;
    end
  end

  always_comb begin
    state_n  = state;
    ctrl_n   = ctrl;
    preset_n = preset;
    count_n  = count;
    pend_n   = pend;

    unique case (state)
      IDLE: begin
        if (ctrl[EN]) state_n = LOAD;
      end
      LOAD: begin
        count_n = preset;
        state_n = CNT;
      end
      CNT: begin
        if (!ctrl[EN]) begin
          state_n = IDLE;
        end else if (count > 32'd1) begin
          count_n = count - 32'd1;
        end else begin
          count_n = '0;
          pend_n  = 1'b1;
          state_n = INT;
        end
      end
      INT: begin
        if (ctrl[MODE_HI:MODE_LO] == MODE_RELOAD)
          pend_n = 1'b0;
        else
          ctrl_n[EN] = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Bus writes come last so they win over the FSM.
    if (WE) begin
      unique case (Addr)
        ADDR_CTRL: begin
          ctrl_n = WD[3:0];
          pend_n = 1'b0;
        end
        ADDR_PRESET: begin
          preset_n = WD;
          pend_n   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    unique case (Addr)
      ADDR_CTRL:   RD = {28'b0, ctrl};
      ADDR_PRESET: RD = preset;
      ADDR_COUNT:  RD = count;
      default:     RD = '0;
    endcase
  end

  assign IRQ = ctrl[IM] & pend;

endmodule

// File: tb/tb_timer.sv
// tb_timer: self-checking bench for the timer peripheral.
// Vector table, directed sequences, and a random run vs a model.
module tb_timer;

  logic        Clock;
  logic        Reset;
  logic [3:2]  Addr;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        IRQ;

  int errors = 0;
  int checks = 0;

  timer dut (
    .Clock (Clock),
    .Reset (Reset),
    .Addr  (Addr),
    .WE    (WE),
    .WD    (WD),
    .RD    (RD),
    .IRQ   (IRQ)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        rst;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;
  } vec_t;

  vec_t vecs [10];

  // Reference model: registers plus a phase counter
  // 0 waiting, 1 about to load, 2 counting, 3 expired.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_pend;
  int          m_phase;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic we,
                     input logic [1:0] a,
                     input logic [31:0] wd);
    @(negedge Clock);
    Reset = r;
    WE    = we;
    Addr  = a;
    WD    = wd;
    @(posedge Clock);
    #1;
  endtask

  task automatic model_reset();
    m_ctrl   = '0;
    m_preset = '0;
    m_count  = '0;
    m_pend   = 1'b0;
    m_phase  = 0;
  endtask

  task automatic model_step(input logic r, input logic we,
                            input logic [1:0] a,
                            input logic [31:0] wd);
    logic [3:0]  c;
    logic [31:0] p, n;
    logic        pd;
    int          ph;
    if (r) begin
      model_reset();
      return;
    end
    c = m_ctrl; p = m_preset; n = m_count;
    pd = m_pend; ph = m_phase;
    if (m_phase == 0) begin
      if (m_ctrl[0]) ph = 1;
    end else if (m_phase == 1) begin
      n = m_preset;
      ph = 2;
    end else if (m_phase == 2) begin
      if (!m_ctrl[0]) ph = 0;
      else if (m_count >= 2) n = m_count - 1;
      else begin
        n = 0; pd = 1'b1; ph = 3;
      end
    end else begin
      if (m_ctrl[2:1] == 2'b01) pd = 1'b0;
      else c[0] = 1'b0;
      ph = 0;
    end
    if (we && a == 2'd0) begin
      c = wd[3:0]; pd = 1'b0;
    end
    if (we && a == 2'd1) begin
      p = wd; pd = 1'b0;
    end
    m_ctrl = c; m_preset = p; m_count = n;
    m_pend = pd; m_phase = ph;
  endtask

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {28'b0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    logic [31:0] e;
    Reset = 1'b1; WE = 1'b0; Addr = '0; WD = '0;

    vecs[0] = '{1, 0, 2'd0, 32'h0, 32'h0, 0};
    vecs[1] = '{1, 1, 2'd1, 32'h55, 32'h0, 0};
    vecs[2] = '{0, 0, 2'd0, 32'h0, 32'h0, 0};
    vecs[3] = '{0, 0, 2'd1, 32'h0, 32'h0, 0};
    vecs[4] = '{0, 0, 2'd2, 32'h0, 32'h0, 0};
    vecs[5] = '{0, 1, 2'd2, 32'h1234, 32'h0, 0};
    vecs[6] = '{0, 1, 2'd3, 32'hABCD, 32'h0, 0};
    vecs[7] = '{0, 1, 2'd0, 32'hFFFFFFF0, 32'h0, 0};
    vecs[8] = '{0, 1, 2'd1, 32'hDEADBEEF,
                32'hDEADBEEF, 0};
    vecs[9] = '{0, 0, 2'd2, 32'h0, 32'h0, 0};

    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].wd);
      chk($sformatf("vec%0d_rd", i), RD, vecs[i].rd);
      chk($sformatf("vec%0d_irq", i), 32'(IRQ),
          32'(vecs[i].irq));
    end

    // Auto-reload, preset 5: period 8, one-cycle pulses.
    cyc(1, 0, 2'd0, 0);
    cyc(0, 1, 2'd1, 5);
    cyc(0, 1, 2'd0, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      cyc(0, 0, 2'd2, 0);
      if (k >= 2 && k <= 7) e = 32'(7 - k);
      else if (k >= 10 && k <= 15) e = 32'(15 - k);
      else e = 0;
      chk($sformatf("rl_cnt%0d", k), RD, e);
      chk($sformatf("rl_irq%0d", k), 32'(IRQ),
          32'(k == 7 || k == 15));
    end

    // One-shot, preset 3: sticky IRQ from cycle 5.
    cyc(1, 0, 2'd0, 0);
    cyc(0, 1, 2'd1, 3);
    cyc(0, 1, 2'd0, 32'h9);
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 0, 2'd0, 0);
      chk($sformatf("os_irq%0d", k), 32'(IRQ),
          32'(k >= 5));
    end
    chk("os_ctrl", RD, 32'h8);
    cyc(0, 1, 2'd0, 32'h8);
    chk("os_clr_irq", 32'(IRQ), 0);
    cyc(0, 0, 2'd0, 0);
    chk("os_clr_irq2", 32'(IRQ), 0);

    // Masked interrupt never shows.
    cyc(1, 0, 2'd0, 0);
    cyc(0, 1, 2'd1, 2);
    cyc(0, 1, 2'd0, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 0, 2'd0, 0);
      chk($sformatf("mk_irq%0d", k), 32'(IRQ), 0);
    end
    cyc(0, 1, 2'd0, 32'h8);
    chk("mk_ctrl", RD, 32'h8);
    for (int k = 1; k <= 3; k++) begin
      cyc(0, 0, 2'd0, 0);
      chk($sformatf("mk_after%0d", k), 32'(IRQ), 0);
    end

    // Stop mid-count: frozen at 91.
    cyc(1, 0, 2'd0, 0);
    cyc(0, 1, 2'd1, 100);
    cyc(0, 1, 2'd0, 32'h1);
    for (int k = 1; k <= 10; k++) cyc(0, 0, 2'd2, 0);
    chk("st_run", RD, 92);
    cyc(0, 1, 2'd0, 0);
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 0, 2'd2, 0);
      chk($sformatf("st_cnt%0d", k), RD, 91);
      chk($sformatf("st_irq%0d", k), 32'(IRQ), 0);
    end

    // Random traffic against the model.
    cyc(1, 0, 2'd0, 0);
    model_reset();
    for (int k = 0; k < 3000; k++) begin
      logic        r, we;
      logic [1:0]  a;
      logic [31:0] wd;
      r  = ($urandom_range(0, 299) == 0);
      we = ($urandom_range(0, 9) == 0);
      a  = 2'($urandom_range(0, 3));
      if (a == 2'd1) wd = $urandom_range(0, 6);
      else if ($urandom_range(0, 3) == 0) wd = $urandom;
      else wd = {28'b0, 4'($urandom_range(0, 15)) | 4'h1};
      cyc(r, we, a, wd);
      model_step(r, we, a, wd);
      chk($sformatf("rnd%0d_rd", k), RD, model_rd(a));
      chk($sformatf("rnd%0d_irq", k), 32'(IRQ),
          32'(m_ctrl[3] & m_pend));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
